uart_core: RTL and testbench

Parametrised single-clock UART: transmitter and receiver sharing one clock, with compile-time data width, parity mode and stop-bit count, and a runtime baud divisor. It replaces the fixed-format two-clock UART top in SoC integrations where both directions run off the same system clock. The receiver oversamples 16x with mid-bit sampling, and reports parity and framing errors separately.

---
 rtl/uart_core_if.sv | 35 +++
 rtl/uart_core.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_core_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_core_if
// Brief    : Tx request, serial lines and rx status bundle for uart_core.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
);
  logic [DIV_WIDTH-1:0]  baud_div;
  logic                  enable;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_busy;
  logic                  serial_out;
  logic                  serial_in;
  logic [DATA_WIDTH-1:0] received_data;
  logic                  data_is_valid;
  logic                  parity_error;
  logic                  frame_error;
  logic                  rx_error;

  modport master (
    output baud_div, enable, i_data, serial_in,
    input  o_busy, serial_out, received_data, data_is_valid,
           parity_error, frame_error, rx_error
  );

  modport slave (
    input  baud_div, enable, i_data, serial_in,
    output o_busy, serial_out, received_data, data_is_valid,
           parity_error, frame_error, rx_error
  );
endinterface
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_core
// Brief    : Single-clock UART, 16x oversampled rx with parity/framing errors.
//            Optional UART_LOOPBACK_EN adds a loopback port (tx -> rx).
// Revision : 1.0 - initial release
// ============================================================================
module uart_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int DIV_WIDTH   = 16
) (
  input  wire        clk,
  input  wire        reset,
`ifdef UART_LOOPBACK_EN
  input  wire        loopback,
`endif
  uart_core_if.slave bus
);

  localparam logic       c_HAS_PAR   = (PARITY_MODE != 0);
  localparam logic       c_ODD       = (PARITY_MODE == 2);
  localparam logic [3:0] c_MID_OS    = 4'd7;
  localparam logic [3:0] c_LAST_OS   = 4'd15;
  localparam logic [3:0] c_LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] c_LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ------------------------------------------------------------------ tx
  state_t                r_tx_state, w_tx_state_nxt;
  logic [DIV_WIDTH-1:0]  r_tx_div, r_tx_cnt;
  logic [3:0]            r_tx_os, r_tx_idx;
  logic [DATA_WIDTH-1:0] r_tx_shift;
  logic                  r_tx_par;
  logic                  r_txd, w_txd_nxt;
  logic                  w_tx_accept, w_tx_tick, w_tx_bit_end;

  assign w_tx_accept  = (r_tx_state == S_IDLE) && bus.enable;
  assign w_tx_tick    = (r_tx_cnt == '0);
  assign w_tx_bit_end = (r_tx_state != S_IDLE) && w_tx_tick && (r_tx_os == c_LAST_OS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= S_IDLE;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  // The line value is registered together with the state so serial_out never glitches.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_txd_nxt      = r_txd;
    case (r_tx_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        if (bus.enable) begin
          w_tx_state_nxt = S_START;
          w_txd_nxt      = 1'b0;
        end
      end
      S_START: begin
        if (w_tx_bit_end) begin
          w_tx_state_nxt = S_DATA;
          w_txd_nxt      = r_tx_shift[0];
        end
      end
      S_DATA: begin
        if (w_tx_bit_end) begin
          if (r_tx_idx == c_LAST_DATA) begin
            if (c_HAS_PAR) begin
              w_tx_state_nxt = S_PARITY;
              w_txd_nxt      = r_tx_par;
            end else begin
              w_tx_state_nxt = S_STOP;
              w_txd_nxt      = 1'b1;
            end
          end else begin
            w_txd_nxt = r_tx_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_tx_bit_end) begin
          w_tx_state_nxt = S_STOP;
          w_txd_nxt      = 1'b1;
        end
      end
      S_STOP: begin
        if (w_tx_bit_end && (r_tx_idx == c_LAST_STOP)) begin
          w_tx_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_tx_state_nxt = S_IDLE;
        w_txd_nxt      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_div   <= '0;
      r_tx_cnt   <= '0;
      r_tx_os    <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
    end else if (w_tx_accept) begin
      r_tx_div   <= bus.baud_div;
      r_tx_cnt   <= bus.baud_div;
      r_tx_os    <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= bus.i_data;
      r_tx_par   <= (^bus.i_data) ^ c_ODD;
    end else if (r_tx_state != S_IDLE) begin
      r_tx_cnt <= w_tx_tick ? r_tx_div : r_tx_cnt - 1'b1;
      if (w_tx_tick) begin
        r_tx_os <= r_tx_os + 4'd1;
      end
      if (w_tx_bit_end) begin
        if (((r_tx_state == S_DATA) && (r_tx_idx != c_LAST_DATA)) || (r_tx_state == S_STOP)) begin
          r_tx_idx <= r_tx_idx + 4'd1;
        end else begin
          r_tx_idx <= '0;
        end
        if (r_tx_state == S_DATA) begin
          r_tx_shift <= r_tx_shift >> 1;
        end
      end
    end
  end

  assign bus.o_busy = (r_tx_state != S_IDLE);

  logic w_rx_line;
`ifdef UART_LOOPBACK_EN
  assign bus.serial_out = loopback ? 1'b1  : r_txd;
  assign w_rx_line      = loopback ? r_txd : bus.serial_in;
`else
  assign bus.serial_out = r_txd;
  assign w_rx_line      = bus.serial_in;
`endif

  // ------------------------------------------------------------------ rx
  state_t                r_rx_state, w_rx_state_nxt;
  logic                  r_sync1, r_sync2, r_rx_prev;
  logic [DIV_WIDTH-1:0]  r_rx_div, r_rx_cnt;
  logic [3:0]            r_rx_os, r_rx_idx;
  logic [DATA_WIDTH-1:0] r_rx_shift, r_rx_data;
  logic                  r_rx_pbit, r_rx_ferr_acc;
  logic                  r_rx_valid, r_rx_perr, r_rx_ferr;
  logic                  w_rx_start, w_rx_tick, w_rx_sample, w_rx_done;

  assign w_rx_start  = (r_rx_state == S_IDLE) && r_rx_prev && !r_sync2;
  assign w_rx_tick   = (r_rx_cnt == '0);
  assign w_rx_sample = (r_rx_state != S_IDLE) && w_rx_tick && (r_rx_os == c_MID_OS);
  assign w_rx_done   = (r_rx_state == S_STOP) && w_rx_sample && (r_rx_idx == c_LAST_STOP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= S_IDLE;
    end else begin
      r_sync1    <= w_rx_line;
      r_sync2    <= r_sync1;
      r_rx_prev  <= r_sync2;
      r_rx_state <= w_rx_state_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      S_IDLE: begin
        if (w_rx_start) begin
          w_rx_state_nxt = S_START;
        end
      end
      S_START: begin
        // A line back high at mid start bit is a glitch, not a frame.
        if (w_rx_sample) begin
          w_rx_state_nxt = r_sync2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_rx_sample && (r_rx_idx == c_LAST_DATA)) begin
          w_rx_state_nxt = c_HAS_PAR ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_rx_sample) begin
          w_rx_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_rx_done) begin
          w_rx_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_rx_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_div      <= '0;
      r_rx_cnt      <= '0;
      r_rx_os       <= '0;
      r_rx_idx      <= '0;
      r_rx_shift    <= '0;
      r_rx_pbit     <= 1'b0;
      r_rx_ferr_acc <= 1'b0;
    end else if (w_rx_start) begin
      r_rx_div      <= bus.baud_div;
      r_rx_cnt      <= bus.baud_div;
      r_rx_os       <= '0;
      r_rx_idx      <= '0;
      r_rx_ferr_acc <= 1'b0;
    end else if (r_rx_state != S_IDLE) begin
      r_rx_cnt <= w_rx_tick ? r_rx_div : r_rx_cnt - 1'b1;
      if (w_rx_tick) begin
        r_rx_os <= r_rx_os + 4'd1;
      end
      if (w_rx_sample) begin
        case (r_rx_state)
          S_DATA: begin
            r_rx_shift <= {r_sync2, r_rx_shift[DATA_WIDTH-1:1]};
            r_rx_idx   <= (r_rx_idx == c_LAST_DATA) ? 4'd0 : r_rx_idx + 4'd1;
          end
          S_PARITY: begin
            r_rx_pbit <= r_sync2;
          end
          S_STOP: begin
            r_rx_idx <= r_rx_idx + 4'd1;
            if (!r_sync2) begin
              r_rx_ferr_acc <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Visible rx results change only on the cycle after the final stop sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_valid <= w_rx_done;
      if (w_rx_done) begin
        r_rx_data <= r_rx_shift;
        r_rx_perr <= c_HAS_PAR && (((^r_rx_shift) ^ r_rx_pbit) != c_ODD);
        r_rx_ferr <= r_rx_ferr_acc | !r_sync2;
      end
    end
  end

  assign bus.received_data = r_rx_data;
  assign bus.data_is_valid = r_rx_valid;
  assign bus.parity_error  = r_rx_perr;
  assign bus.frame_error   = r_rx_ferr;
  assign bus.rx_error      = r_rx_perr | r_rx_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// tb_uart_core: directed checks of uart_core in an even/1-stop build and an odd/2-stop build.
module tb_uart_core;
  logic clk = 1'b0;
  logic reset;
  logic tb_loop;
  logic r_rx_ev, r_rx_od;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ev_cnt = 0;
  int   od_cnt = 0;
  logic [7:0] ev_last = '0, ev_prev = '0, od_last = '0;

  always #5 clk = ~clk;

  uart_core_if #(.DATA_WIDTH(8), .DIV_WIDTH(16)) ev_if ();
  uart_core_if #(.DATA_WIDTH(8), .DIV_WIDTH(16)) od_if ();

`ifdef UART_LOOPBACK_EN
  assign ev_if.serial_in = r_rx_ev;
`else
  assign ev_if.serial_in = tb_loop ? ev_if.serial_out : r_rx_ev;
`endif
  assign od_if.serial_in = r_rx_od;

  uart_core #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1), .DIV_WIDTH(16)) u_even (
    .clk      (clk),
    .reset    (reset),
`ifdef UART_LOOPBACK_EN
    .loopback (tb_loop),
`endif
    .bus      (ev_if)
  );

  uart_core #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(2), .DIV_WIDTH(16)) u_odd (
    .clk      (clk),
    .reset    (reset),
`ifdef UART_LOOPBACK_EN
    .loopback (1'b0),
`endif
    .bus      (od_if)
  );

  always @(negedge clk) begin
    if (ev_if.data_is_valid === 1'b1) begin
      ev_cnt++;
      ev_prev = ev_last;
      ev_last = ev_if.received_data;
    end
    if (od_if.data_is_valid === 1'b1) begin
      od_cnt++;
      od_last = od_if.received_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Frame bit vectors, bit 0 on the line first.
  function automatic logic [15:0] ev_frame(input logic [7:0] d, input logic p);
    return {5'b0, 1'b1, p, d, 1'b0};
  endfunction

  function automatic logic [15:0] od_frame(input logic [7:0] d, input logic p, input logic s2);
    return {4'b0, s2, 1'b1, p, d, 1'b0};
  endfunction

  task automatic send_frame(input logic odd_dut, input logic [15:0] bits, input int nbits, input int cpb);
    for (int i = 0; i < nbits; i++) begin
      if (odd_dut) r_rx_od = bits[i];
      else         r_rx_ev = bits[i];
      repeat (cpb) @(negedge clk);
    end
    if (odd_dut) r_rx_od = 1'b1;
    else         r_rx_ev = 1'b1;
  endtask

  task automatic wait_ev(input int target, input int budget);
    for (int k = 0; k < budget && ev_cnt < target; k++) @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int         n0;
    int         busy_cyc;
    int         gap;
    logic       seen_fall;
    logic [10:0] tx_bits;

    reset = 1'b1; tb_loop = 1'b0; r_rx_ev = 1'b1; r_rx_od = 1'b1;
    ev_if.enable = 1'b0; ev_if.i_data = '0; ev_if.baud_div = 16'd0;
    od_if.enable = 1'b0; od_if.i_data = '0; od_if.baud_div = 16'd3;
    repeat (3) @(negedge clk);

    check("rst_serial_out", ev_if.serial_out, 1);
    check("rst_busy", ev_if.o_busy, 0);
    check("rst_rx_data", ev_if.received_data, 0);
    check("rst_valid", ev_if.data_is_valid, 0);
    check("rst_perr", ev_if.parity_error, 0);
    check("rst_ferr", ev_if.frame_error, 0);
    check("rst_rx_error", ev_if.rx_error, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic tx of 0xA5, even parity, 16 cycles per bit; a second enable while busy is dropped.
    ev_if.i_data = 8'hA5; ev_if.enable = 1'b1;
    @(negedge clk);
    ev_if.enable = 1'b0;
    check("tx_busy_rise", ev_if.o_busy, 1);
    check("tx_start_bit", ev_if.serial_out, 0);
    busy_cyc = 0; tx_bits = '0;
    for (int c = 0; c < 260; c++) begin
      if ((c % 16) == 8 && c < 176) tx_bits[c / 16] = ev_if.serial_out;
      if (ev_if.o_busy) busy_cyc++;
      if (c == 50) begin ev_if.i_data = 8'h3C; ev_if.enable = 1'b1; end
      if (c == 51) ev_if.enable = 1'b0;
      @(negedge clk);
    end
    check("tx_bits", tx_bits, 11'b10101001010);
    check("tx_busy_cycles", busy_cyc, 176);
    check("tx_idle_line", ev_if.serial_out, 1);

    // Odd parity, 2 stop bits, 64 cycles per bit.
    n0 = od_cnt;
    send_frame(1'b1, od_frame(8'h3C, 1'b1, 1'b1), 12, 64);
    repeat (10) @(negedge clk);
    check("odd_rx_count", od_cnt - n0, 1);
    check("odd_rx_data", od_if.received_data, 8'h3C);
    check("odd_rx_error", od_if.rx_error, 0);

    n0 = od_cnt;
    send_frame(1'b1, od_frame(8'hC3, 1'b0, 1'b1), 12, 64);
    repeat (10) @(negedge clk);
    check("perr_count", od_cnt - n0, 1);
    check("perr_data", od_if.received_data, 8'hC3);
    check("perr_flag", od_if.parity_error, 1);
    check("perr_ferr", od_if.frame_error, 0);
    check("perr_rx_error", od_if.rx_error, 1);

    n0 = od_cnt;
    send_frame(1'b1, od_frame(8'h5A, 1'b1, 1'b0), 12, 64);
    repeat (100) @(negedge clk);
    check("ferr_count", od_cnt - n0, 1);
    check("ferr_data", od_if.received_data, 8'h5A);
    check("ferr_flag", od_if.frame_error, 1);
    check("ferr_perr", od_if.parity_error, 0);

    send_frame(1'b1, od_frame(8'h0F, 1'b1, 1'b1), 12, 64);
    repeat (10) @(negedge clk);
    check("clear_rx_error", od_if.rx_error, 0);
    check("clear_data", od_last, 8'h0F);

    // False start: 4 low cycles at 16 cycles per bit.
    n0 = ev_cnt;
    r_rx_ev = 1'b0;
    repeat (4) @(negedge clk);
    r_rx_ev = 1'b1;
    repeat (100) @(negedge clk);
    check("false_start_no_valid", ev_cnt - n0, 0);
    send_frame(1'b0, ev_frame(8'h55, 1'b0), 11, 16);
    repeat (10) @(negedge clk);
    check("after_false_count", ev_cnt - n0, 1);
    check("after_false_data", ev_if.received_data, 8'h55);
    check("after_false_err", ev_if.rx_error, 0);

    // Back-to-back frames with enable held, received over loopback.
    tb_loop = 1'b1;
    repeat (5) @(negedge clk);
    n0 = ev_cnt;
    ev_if.i_data = 8'h01; ev_if.enable = 1'b1;
    @(negedge clk);
    ev_if.i_data = 8'hFE;
    gap = 0; seen_fall = 1'b0;
    for (int k = 0; k < 400 && !(seen_fall && ev_if.o_busy); k++) begin
      if (!ev_if.o_busy) begin seen_fall = 1'b1; gap++; end
      @(negedge clk);
    end
    ev_if.enable = 1'b0;
    // busy drops only for the single cycle in which the next frame is accepted
    check("b2b_gap", gap, 1);
    wait_ev(n0 + 2, 600);
    check("b2b_count", ev_cnt - n0, 2);
    check("b2b_first", ev_prev, 8'h01);
    check("b2b_second", ev_last, 8'hFE);
    tb_loop = 1'b0;
    repeat (20) @(negedge clk);

    // Reset at bit 4 of a concurrent tx and rx frame.
    n0 = ev_cnt;
    ev_if.i_data = 8'h00; ev_if.enable = 1'b1; r_rx_ev = 1'b0;
    @(negedge clk);
    ev_if.enable = 1'b0;
    repeat (71) @(negedge clk);
    reset = 1'b1; r_rx_ev = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_line_high", ev_if.serial_out, 1);
    check("midrst_busy_low", ev_if.o_busy, 0);
    check("midrst_rx_data", ev_if.received_data, 0);
    repeat (300) @(negedge clk);
    check("midrst_no_valid", ev_cnt - n0, 0);

    tb_loop = 1'b1;
    repeat (5) @(negedge clk);
    n0 = ev_cnt;
    ev_if.i_data = 8'h81; ev_if.enable = 1'b1;
    @(negedge clk);
    ev_if.enable = 1'b0;
    wait_ev(n0 + 1, 400);
    check("post_rst_count", ev_cnt - n0, 1);
    check("post_rst_data", ev_last, 8'h81);
    check("post_rst_err", ev_if.rx_error, 0);
    tb_loop = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
